// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: frame constants and TX state encoding shared by the UART command-link transmitter and decoder.
package uart_frame_pkg;
  localparam logic [7:0] FRAME_HDR0 = 8'hEB;
  localparam logic [7:0] FRAME_HDR1 = 8'h9C;
  localparam int PAYLOAD_BYTES = 8;
  localparam logic [31:0] ADDR_DELAY_TAB = 32'h0200_2000;
  typedef enum logic [2:0] {ST_IDLE, ST_HDR0, ST_HDR1, ST_PAY, ST_SUM, ST_GAP} tx_state_t;
  function automatic logic [7:0] payload_byte(input logic [63:0] w, input logic [2:0] k);
    return w[{k, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/uart_cmd_fifo.sv
// uart_cmd_fifo: synchronous command FIFO with registered occupancy count and full/empty flags.
module uart_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wr, rd;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign wr = push & !full;
  assign rd = pop & !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: queues delay-write commands and serialises each as EB 9C, 8 little-endian payload bytes, optional checksum.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2,
  parameter bit APPEND_SUM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        I_CMD_VALID,
  output logic        O_CMD_READY,
  input  logic [31:0] I_CMD_ADDR,
  input  logic [3:0]  I_CMD_AWG_ID,
  input  logic [3:0]  I_CMD_PORT_ID,
  input  logic [23:0] I_CMD_DELAY,
  output logic [7:0]  frame_data_out,
  output logic        frame_data_ena,
  input  logic        I_BYTE_READY,
  output logic        O_BUSY,
  output logic        O_FRAME_DONE
);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam logic [2:0] LAST = 3'(PAYLOAD_BYTES - 1);
  tx_state_t state, state_d;
  logic [63:0] fifo_dout, shadow;
  logic fifo_full, fifo_empty, push, pop, xfer, gap_last, rdy_en, ena_d;
  logic [2:0] idx, idx_d;
  logic [7:0] sum, sum_d, data_d;
  logic [GW-1:0] gap_cnt, gap_d;
  assign O_CMD_READY = rdy_en & !fifo_full;
  assign push = I_CMD_VALID & O_CMD_READY;
  assign xfer = frame_data_ena & I_BYTE_READY;
  assign gap_last = gap_cnt == GW'(GAP_CYCLES - 1);
  // the next command is fetched on the gap's final cycle so back-to-back frames are spaced by exactly GAP_CYCLES
  assign pop = !fifo_empty & (state == ST_IDLE | (state == ST_GAP & gap_last));
  assign O_BUSY = state != ST_IDLE;
  assign O_FRAME_DONE = xfer & (APPEND_SUM ? state == ST_SUM : (state == ST_PAY && idx == LAST));
  uart_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(64)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .din({I_CMD_ADDR, I_CMD_AWG_ID, I_CMD_PORT_ID, I_CMD_DELAY}),
    .pop(pop),
    .dout(fifo_dout),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  // outputs are computed for the next state so the byte register only moves on a transfer
  always_comb begin
    state_d = state;
    idx_d = idx;
    sum_d = xfer ? sum + frame_data_out : sum;
    data_d = frame_data_out;
    ena_d = frame_data_ena;
    gap_d = gap_cnt;
    if (pop) begin
      state_d = ST_HDR0;
      ena_d = 1'b1;
      data_d = FRAME_HDR0;
      sum_d = '0;
      idx_d = '0;
      gap_d = '0;
    end else begin
      case (state)
        ST_GAP: begin
          gap_d = gap_last ? '0 : gap_cnt + GW'(1);
          state_d = gap_last ? ST_IDLE : ST_GAP;
        end
        ST_HDR0: if (xfer) begin
          state_d = ST_HDR1;
          data_d = FRAME_HDR1;
        end
        ST_HDR1: if (xfer) begin
          state_d = ST_PAY;
          data_d = payload_byte(shadow, 3'd0);
        end
        ST_PAY: if (xfer) begin
          idx_d = idx + 3'd1;
          state_d = idx != LAST ? ST_PAY : APPEND_SUM ? ST_SUM : ST_GAP;
          ena_d = idx != LAST || APPEND_SUM;
          data_d = idx != LAST ? payload_byte(shadow, idx + 3'd1) : APPEND_SUM ? 8'd0 - sum_d : 8'd0;
        end
        ST_SUM: if (xfer) begin
          state_d = ST_GAP;
          ena_d = 1'b0;
          data_d = '0;
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      idx <= '0;
      sum <= '0;
      gap_cnt <= '0;
      frame_data_out <= '0;
      frame_data_ena <= 1'b0;
      shadow <= '0;
      rdy_en <= 1'b0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      sum <= sum_d;
      gap_cnt <= gap_d;
      frame_data_out <= data_d;
      frame_data_ena <= ena_d;
      shadow <= pop ? fifo_dout : shadow;
      rdy_en <= 1'b1;
    end
endmodule
